// File: rtl/i2s_pkg.sv
// Shared constants and width helpers for the I2S/TDM transceiver.
package i2s_pkg;
  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  function automatic int bit_cnt_w(input int slot_bits);
    return (slot_bits > 1) ? $clog2(slot_bits) : 1;
  endfunction

  function automatic int slot_cnt_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/i2s_slot_timer.sv
// Word-select synchroniser, frame-edge detection and bit/slot counters.
// All outputs describe the bit being sampled at the current sck posedge.
module i2s_slot_timer import i2s_pkg::*; #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int CH_W      = slot_cnt_w(CHANNELS),
  parameter int BC_W      = bit_cnt_w(SLOT_BITS)
) (
  input  logic            sck,
  input  logic            reset,
  input  logic            ws,
  input  logic            lj_mode,
  output logic            bit_vld,
  output logic            slot_start,
  output logic [BC_W-1:0] bit_idx,
  output logic [CH_W-1:0] slot_idx,
  output logic            short_hit,
  output logic [BC_W-1:0] short_bits,
  output logic [CH_W-1:0] short_slot
);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(SLOT_BITS - 1);
  localparam logic [BC_W-1:0] LAST_CAP  = BC_W'(WIDTH - 1);
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(CHANNELS - 1);

  logic            ws_q1, ws_q2, mode_q, running;
  logic [BC_W-1:0] bit_cnt;
  logic [CH_W-1:0] slot_cnt;
  logic            mode, ws_edge, new_lvl, frame_edge;
  logic [CH_W-1:0] frame_slot;

  // While idle or held the live mode is used so the very first edge is seen correctly.
  always_comb begin
    mode       = running ? mode_q : lj_mode;
    ws_edge    = (mode == MODE_I2S) ? (ws_q1 ^ ws_q2) : (ws ^ ws_q1);
    new_lvl    = (mode == MODE_LJ) ? ws : ws_q1;
    frame_edge = ws_edge && ((CHANNELS == 2) || new_lvl);
    frame_slot = (CHANNELS == 2) ? CH_W'(new_lvl) : '0;
    bit_vld    = frame_edge || running;
    slot_start = frame_edge || (running && bit_cnt == '0);
    bit_idx    = frame_edge ? '0 : bit_cnt;
    slot_idx   = frame_edge ? frame_slot : slot_cnt;
    short_hit  = frame_edge && running && bit_cnt != '0 && bit_cnt <= LAST_CAP;
    short_bits = bit_cnt;
    short_slot = slot_cnt;
  end

  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      ws_q1    <= 1'b0;
      ws_q2    <= 1'b0;
      mode_q   <= 1'b0;
      running  <= 1'b0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      ws_q1 <= ws;
      ws_q2 <= ws_q1;
      if (slot_start) mode_q <= lj_mode;
      if (bit_vld) begin
        if (bit_idx == LAST_BIT) begin
          bit_cnt <= '0;
          // past the last slot the counters park until the next frame edge
          if (slot_idx == LAST_SLOT) begin
            running <= 1'b0;
          end else begin
            slot_cnt <= slot_idx + CH_W'(1);
            running  <= 1'b1;
          end
        end else begin
          bit_cnt  <= bit_idx + BC_W'(1);
          slot_cnt <= slot_idx;
          running  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/i2s_tdm_transceiver.sv
// I2S / left-justified / TDM transceiver: RX shifter and output regs,
// per-channel TX holding registers and the negedge TX shifter.
module i2s_tdm_transceiver import i2s_pkg::*; #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int CH_W      = slot_cnt_w(CHANNELS)
) (
  input  logic             sck,
  input  logic             reset,
  input  logic             ws,
  input  logic             sd,
  input  logic             lj_mode,
  input  logic             loopback,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [CH_W-1:0]  tx_chan,
  input  logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic [CH_W-1:0]  rx_chan,
  output logic             rx_valid,
  output logic             rx_parity,
  output logic             sd_out,
  output logic             short_err
);
  localparam int BC_W = bit_cnt_w(SLOT_BITS);
  localparam logic [BC_W-1:0] LAST_CAP = BC_W'(WIDTH - 1);

  logic            bit_vld, slot_start, short_hit;
  logic [BC_W-1:0] bit_idx, short_bits;
  logic [CH_W-1:0] slot_idx, short_slot;

  i2s_slot_timer #(
    .WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .CHANNELS(CHANNELS), .CH_W(CH_W), .BC_W(BC_W)
  ) u_timer (
    .sck(sck), .reset(reset), .ws(ws), .lj_mode(lj_mode),
    .bit_vld(bit_vld), .slot_start(slot_start), .bit_idx(bit_idx), .slot_idx(slot_idx),
    .short_hit(short_hit), .short_bits(short_bits), .short_slot(short_slot)
  );

  logic [WIDTH-1:0] rx_sh, cap_word, short_word;
  logic [WIDTH:0]   sh_ext;
  logic             capture, cap_last;

  // A truncated slot keeps its captured MSBs left-aligned with zero LSBs.
  always_comb begin
    sh_ext     = {rx_sh, sd};
    cap_word   = sh_ext[WIDTH-1:0];
    short_word = rx_sh << (WIDTH - int'(short_bits));
    capture    = bit_vld && bit_idx <= LAST_CAP;
    cap_last   = bit_vld && bit_idx == LAST_CAP;
  end

  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_chan   <= '0;
      rx_valid  <= 1'b0;
      rx_parity <= 1'b0;
      short_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (capture) rx_sh <= (bit_idx == '0) ? WIDTH'(sd) : cap_word;
      if (short_hit) begin
        rx_data   <= short_word;
        rx_chan   <= short_slot;
        rx_parity <= ^short_word;
        rx_valid  <= 1'b1;
        short_err <= 1'b1;
      end else if (cap_last) begin
        rx_data   <= cap_word;
        rx_chan   <= slot_idx;
        rx_parity <= ^cap_word;
        rx_valid  <= 1'b1;
      end
    end
  end

  logic [WIDTH-1:0] tx_hold [CHANNELS];
  logic [WIDTH-1:0] tx_sh;
  logic [CH_W-1:0]  tx_slot;
  logic             lb_q, tx_ld;

  // The loopback write comes last so it wins over a same-cycle host write.
  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) tx_hold[c] <= '0;
      lb_q    <= 1'b0;
      tx_ld   <= 1'b0;
      tx_slot <= '0;
    end else begin
      tx_ld <= slot_start;
      if (slot_start) begin
        tx_slot <= slot_idx;
        lb_q    <= loopback;
      end
      if (tx_load && !lb_q) tx_hold[tx_chan] <= tx_data;
      if (lb_q && rx_valid) tx_hold[rx_chan] <= rx_data;
    end
  end

  always_ff @(negedge sck or posedge reset) begin
    if (reset)      tx_sh <= '0;
    else if (tx_ld) tx_sh <= tx_hold[tx_slot];
    else            tx_sh <= tx_sh << 1;
  end

  assign sd_out = tx_sh[WIDTH-1];
endmodule
